// File: rtl/pcpi_pkg.sv
// rtl/pcpi_pkg.sv - shared constants, FSM state type and instruction encoder for the PCPI initiator
package pcpi_pkg;

    localparam logic [6:0] CUSTOM0     = 7'b0001011;

    localparam logic [2:0] F3_LOAD     = 3'b000;
    localparam logic [2:0] F3_CLEAR    = 3'b101;
    localparam logic [2:0] F3_START    = 3'b111;

    localparam logic [4:0] A_BASE      = 5'd0;
    localparam logic [4:0] B_BASE      = 5'd9;
    localparam logic [4:0] BIAS_BASE   = 5'd18;
    localparam logic [4:0] THRESH_ADDR = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_GAP   = 2'd3
    } pcpi_state_e;

    // Pack a high-level command into a custom-0 style instruction word
    function automatic logic [31:0] encode_insn(
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [4:0]  addr,
        input logic [15:0] value
    );
        return {1'b0, value, funct3, addr, opcode};
    endfunction

endpackage

// File: rtl/pcpi_cmd_initiator.sv
// rtl/pcpi_cmd_initiator.sv - command-stream to PCPI handshake initiator with timeout and response stream
module pcpi_cmd_initiator
    import pcpi_pkg::*;
#(
    parameter logic [6:0] OPCODE         = CUSTOM0,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         GAP_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_funct3,
    input  logic [4:0]  cmd_addr,
    input  logic [15:0] cmd_value,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam int             GW      = $clog2(GAP_CYCLES + 1) + 1;

    pcpi_state_e    state_q, state_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           pcpi_valid_q, pcpi_valid_d;
    logic [31:0]    insn_q, insn_d;
    logic [CW-1:0]  to_cnt_q, to_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic           rsp_wr_q, rsp_wr_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic           busy_q, busy_d;

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_d       = state_q;
        pcpi_valid_d  = pcpi_valid_q;
        insn_d        = insn_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_wr_d      = rsp_wr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    insn_d       = encode_insn(OPCODE, cmd_funct3, cmd_addr, cmd_value);
                    pcpi_valid_d = 1'b1;
                    to_cnt_d     = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // pcpi_valid is always high here, so ready is already qualified
                if (pcpi_ready) begin
                    rsp_data_d    = pcpi_rd;
                    rsp_wr_d      = pcpi_wr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    pcpi_valid_d  = 1'b0;
                    gap_cnt_d     = '0;
                    state_d       = ST_RESP;
                end else if (pcpi_wait) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    rsp_data_d    = '0;
                    rsp_wr_d      = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    pcpi_valid_d  = 1'b0;
                    gap_cnt_d     = '0;
                    state_d       = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                // Response-hold cycles already have pcpi_valid low, so they count toward the gap
                if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
                if (int'(gap_cnt_q) + 1 >= GAP_CYCLES) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                pcpi_valid_d = 1'b0;
                rsp_valid_d  = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; async reset drops any in-flight command and response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            pcpi_valid_q  <= 1'b0;
            insn_q        <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_wr_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            pcpi_valid_q  <= pcpi_valid_d;
            insn_q        <= insn_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign pcpi_valid  = pcpi_valid_q;
    assign pcpi_insn   = insn_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;

endmodule

// File: doc/pcpi_cmd_initiator.md
Name: pcpi_cmd_initiator

Overview:
- Initiator (CPU-side) end of the PCPI custom-instruction interface that our matrix-multiply coprocessor responds on.
- Accepts high-level commands (funct3, element address, 16-bit value) on a valid/ready stream and encodes them into custom-0 instruction words.
- Drives the pcpi_valid/pcpi_insn handshake and waits for pcpi_ready, honouring pcpi_wait and a timeout.
- Returns the pcpi_rd/pcpi_wr result on a response stream; used by the TinyTapeout wrapper and testbenches in place of a full core.

Parameters:
- OPCODE, 7'b0001011, custom-0 opcode placed in insn[6:0].
- TIMEOUT_CYCLES, 16, max cycles pcpi_valid may stay high with neither pcpi_ready nor pcpi_wait before abort.
- GAP_CYCLES, 1, minimum pcpi_valid-low cycles between transactions (min 1).

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_funct3  in  3  into insn[14:12] (000 load, 101 clear, 111 start)
- cmd_addr  in  5  into insn[11:7]
- cmd_value  in  16  into insn[30:15]
- pcpi_valid  out  1  instruction presented to coprocessor
- pcpi_insn  out  32  encoded instruction
- pcpi_wr  in  1  responder write-back flag
- pcpi_rd  in  32  responder result
- pcpi_wait  in  1  responder busy; suspends timeout
- pcpi_ready  in  1  responder done
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_data  out  32  captured pcpi_rd (0 on timeout)
- rsp_wr  out  1  captured pcpi_wr (0 on timeout)
- rsp_timeout  out  1  transaction aborted by timeout
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, pcpi_insn=0, counters 0. Asserting resetn=0 during any state forces pcpi_valid low immediately and drops the in-flight command and response.
- Encoding: pcpi_insn = {1'b0, cmd_value[15:0], cmd_funct3, cmd_addr, OPCODE}. Registered at command acceptance and stable while pcpi_valid=1.
- FSM states: IDLE, ISSUE, RESP, GAP.
- IDLE: cmd_ready=1. On cmd_valid, latch insn and go to ISSUE. pcpi_valid rises on the next cycle (1-cycle command-to-valid latency).
- ISSUE: pcpi_valid=1.
  - Timeout counter clears each cycle pcpi_wait=1; otherwise it increments.
  - If pcpi_ready=1 in any cycle with pcpi_valid=1, capture rd/wr into rsp_data/rsp_wr, set rsp_timeout=0, go to RESP. pcpi_ready takes priority over wait and timeout in the same cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with pcpi_ready=0 and pcpi_wait=0, set rsp_timeout=1, rsp_data=0, rsp_wr=0, go to RESP.
  - pcpi_valid falls on the cycle after completion.
- RESP: pcpi_valid=0, rsp_valid=1, with rsp fields held stable until rsp_ready. On handshake, go to GAP.
- GAP: pcpi_valid=0 for GAP_CYCLES counted from the first valid-low cycle (RESP cycles count toward the gap), then IDLE.
- cmd_ready=0 in all states except IDLE; commands are never accepted back-to-back without the gap.
- pcpi_ready sampled while pcpi_valid=0 is ignored. The coprocessor holds ready high when idle, so only the valid-high qualification matters.
- Timeout counter width is $clog2(TIMEOUT_CYCLES)+1, with no wrap during wait-extended transactions.
- Response latency: at least 1 cycle from pcpi_valid rise to rsp_valid, since completion is registered.

Decomposition:
- Shared package pcpi_pkg:
  - Opcode constant CUSTOM0.
  - funct3 constants F3_LOAD=3'b000, F3_CLEAR=3'b101, F3_START=3'b111.
  - Address map constants A_BASE=0, B_BASE=9, BIAS_BASE=18, THRESH_ADDR=27.
  - FSM state typedef.
  - Insn-encode function.
- No sub-module is needed; the encoder is a package function, and the FSM plus counter stay in one module.

Test Plan:
- Load command funct3=000, addr=0, value=0x0005 against a responder with ready tied high: pcpi_insn=0x0002800B for exactly 1 cycle of pcpi_valid; then rsp_valid with rsp_data=pcpi_rd, rsp_wr=1, rsp_timeout=0.
- Threshold load funct3=000, addr=27, value=0xFFBA (-70): pcpi_insn=0x7FDD0D8B.
- Start command funct3=111 → pcpi_insn=0x0000700B. Responder drops ready, holds wait for 40 cycles, then ready with rd=0x1234ABCD: no timeout; rsp_data=0x1234ABCD, rsp_timeout=0.
- Responder never asserts ready or wait: pcpi_valid high for exactly 16 cycles, then rsp_timeout=1, rsp_data=0; the next command is accepted only after the gap.
- Backpressure: rsp_ready=0 for 10 cycles keeps rsp_valid=1 with fields stable, cmd_ready=0 and pcpi_valid=0; a second command waits and issues after the handshake plus 1 gap cycle.
- resetn pulsed low mid-ISSUE: pcpi_valid=0 within the same cycle (async); after release busy=0, rsp_valid=0, cmd_ready=1.
